// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder/subtractor built around a
// BITS_PER_CYCLE-wide ripple full-adder slice and a registered carry.
// Operands are captured on an accepted start and consumed LSB-first. The
// result register fills from the MSB side. sum/carry/overflow update only
// when an operation completes and are held otherwise.
// Subtraction is A + ~B + ~cin, so carry reads as NOT borrow.
// BITS_PER_CYCLE must divide WIDTH exactly.
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     opa_r;
    logic [WIDTH-1:0]     opb_r;
    logic [WIDTH-1:0]     res_r;
    logic                 carry_r;
    logic [CW-1:0]        cnt_r;

    logic [BPC-1:0]       psum_s;
    logic                 cout_s;
    logic                 cmsb_s;
    logic [WIDTH+BPC-1:0] cat_s;
    logic [WIDTH-1:0]     res_next_s;
    logic                 last_s;

    // Ripple full-adder slice over the low BPC operand bits; also records the
    // carry entering the slice's top bit, which is bit WIDTH-1 on the last step.
    always_comb begin
        logic c;
        c      = carry_r;
        cmsb_s = 1'b0;
        psum_s = '0;
        for (int i = 0; i < BPC; i++) begin
            cmsb_s    = (i == BPC - 1) ? c : cmsb_s;
            psum_s[i] = opa_r[i] ^ opb_r[i] ^ c;
            c         = (opa_r[i] & opb_r[i]) | (c & (opa_r[i] ^ opb_r[i]));
        end
        cout_s = c;
    end

    // Shift the partial sum into the result from the MSB side.
    always_comb begin
        cat_s      = {psum_s, res_r};
        res_next_s = WIDTH'(cat_s >> BPC);
        last_s     = (cnt_r == CW'(STEPS - 1));
    end

    // Control FSM plus datapath registers; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= S_IDLE;
            opa_r    <= '0;
            opb_r    <= '0;
            res_r    <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa_r   <= a;
                        opb_r   <= b ^ {WIDTH{sub}};
                        carry_r <= cin ^ sub;
                        res_r   <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    opa_r   <= opa_r >> BPC;
                    opb_r   <= opb_r >> BPC;
                    res_r   <= res_next_s;
                    carry_r <= cout_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum      <= res_next_s;
                        carry    <= cout_s;
                        overflow <= cmsb_s ^ cout_s;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= S_DONE;
                    end else begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state_r  <= S_RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: an 8-bit/1-bit-per-cycle
// instance and a 16-bit/4-bit-per-cycle instance share clock and reset.
module tb_serial_adder;

    logic       clk;
    logic       reset;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, carry8, ovf8;
    logic [7:0] sum8;

    logic        start16, sub16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, carry16, ovf16;
    logic [15:0] sum16;

    int total;
    int bad;
    int cyc;
    int pulses;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .sub(sub8), .cin(cin8), .busy(busy8), .done(done8), .sum(sum8),
        .carry(carry8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16),
        .sub(sub16), .cin(cin16), .busy(busy16), .done(done16), .sum(sum16),
        .carry(carry16), .overflow(ovf16)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count negedges after the accepting edge until done8 rises (bounded).
    task automatic wait_done8(output int n);
        n = 0;
        while (done8 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done16(output int n);
        n = 0;
        while (done16 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One full 8-bit operation; checks busy, held old sum, latency and results.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic tc, input logic [7:0] es,
                       input logic ec, input logic eo);
        logic [7:0] prev;
        int n;
        @(negedge clk);
        prev   = sum8;
        a8     = ta;
        b8     = tb;
        sub8   = ts;
        cin8   = tc;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        chk({tag, "_held"}, 32'(sum8), 32'(prev));
        wait_done8(n);
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_sum"}, 32'(sum8), 32'(es));
        chk({tag, "_carry"}, 32'(carry8), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
        chk({tag, "_idle"}, 32'(busy8), 32'd0);
    endtask

    task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [15:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a16     = ta;
        b16     = tb;
        sub16   = 1'b0;
        cin16   = 1'b0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk({tag, "_busy"}, 32'(busy16), 32'd1);
        wait_done16(n);
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_sum"}, 32'(sum16), 32'(es));
        chk({tag, "_carry"}, 32'(carry16), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf16), 32'(eo));
    endtask

    // Linear sequence of directed steps.
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start16 = 1'b0; sub16 = 1'b0; cin16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_carry", 32'(carry8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_sum16", 32'(sum16), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Additions
        op8("add_1_1",   8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
        op8("add_ff_1",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_1",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add_80_80c",8'h80, 8'h80, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1);
        // Subtractions
        op8("sub_5_7",   8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op8("sub_7_5c",  8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        op8("sub_80_1",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

        // start held 3 cycles with operands changed mid-RUN
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; cin8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b0;
        chk("hold_busy", 32'(busy8), 32'd1);
        wait_done8(cyc);
        chk("hold_lat", 32'(cyc), 32'd6);
        chk("hold_sum", 32'(sum8), 32'h30);
        chk("hold_carry", 32'(carry8), 32'd0);

        // Restart in the DONE cycle
        a8 = 8'h03; b8 = 8'h04; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_done_low", 32'(done8), 32'd0);
        chk("b2b_busy", 32'(busy8), 32'd1);
        wait_done8(cyc);
        chk("b2b_lat", 32'(cyc), 32'd8);
        chk("b2b_sum", 32'(sum8), 32'h07);
        @(negedge clk);
        chk("done_one_cycle", 32'(done8), 32'd0);

        // Reset four cycles into RUN
        a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy8), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_busy", 32'(busy8), 32'd0);
        chk("async_sum", 32'(sum8), 32'd0);
        chk("async_carry", 32'(carry8), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        chk("abort_idle", 32'(busy8), 32'd0);

        // Wide instance, 4 bits per cycle
        op16("w16_ffff_1", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        op16("w16_1234",   16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
        op16("w16_7fff_1", 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor that generalises the single-bit half adder (out, carry) to WIDTH-bit operands.
- Processes BITS_PER_CYCLE bits per clock using an internal full-adder slice and a registered carry.
- Uses a start/busy/done handshake.
- Intended as the arithmetic building block for later lab datapaths (accumulator, ALU), where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; ≥ 2.
- BITS_PER_CYCLE, 1, bits added per clock; must divide WIDTH exactly; STEPS = WIDTH/BITS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- sub  input  1  0 = A+B+cin; 1 = A-B-cin, captured on accepted start
- cin  input  1  carry-in (add) / borrow-in (sub), captured on accepted start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result, held until the next accepted start
- carry  output  1  carry-out (add); NOT borrow (sub)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (async, any state, including mid-operation):
  - FSM → IDLE.
  - busy=0, done=0, sum=0, carry=0, overflow=0.
  - Internal operand and carry registers cleared.
  - No done pulse for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 at edge N (accept):
  - opA ← a.
  - opB ← b XOR {WIDTH{sub}}.
  - carry_reg ← cin XOR sub.
  - step counter ← 0.
  - state ← RUN.
  - busy=1 from after edge N.
- IDLE with start=0: stay in IDLE. DONE with start=0: go to IDLE.
- RUN, each edge:
  - Add the low BITS_PER_CYCLE bits of opA, opB and carry_reg.
  - Shift opA and opB right by BITS_PER_CYCLE.
  - Shift the partial sum into the result register from the MSB side.
  - carry_reg ← slice carry-out.
  - Increment the counter.
- RUN, at the edge completing step STEPS (edge N+STEPS):
  - sum ← final result register; carry ← final carry_reg.
  - overflow ← (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), captured during the last slice.
  - state ← DONE; busy=0, done=1 for exactly one cycle.
- Latency: done is high in the cycle after edge N+STEPS. Example: WIDTH=8, BITS_PER_CYCLE=1 gives 8 cycles.
- start while busy=1 is ignored, with no effect on the operation or outputs.
- a, b, sub and cin may change freely after acceptance; only the captured values are used.
- Back-to-back: start=1 in the DONE cycle is accepted; the new RUN begins with no idle gap.
- sum, carry and overflow keep their last result during IDLE and during the next RUN. They update only at completion.
- Subtraction:
  - sum = (A - B - cin) mod 2^WIDTH.
  - carry = 1 iff A ≥ B + cin, unsigned.
- Wrap-around: sum is always modulo 2^WIDTH; carry holds the bit WIDTH.

Test Plan:
- WIDTH=8, BPC=1: a=0x01, b=0x01, sub=0, cin=0, start pulse → done 8 cycles later; sum=0x02, carry=0, overflow=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, carry=1, overflow=0. Then a=0x7F, b=0x01 → sum=0x80, carry=0, overflow=1.
- sub=1: a=0x05, b=0x07, cin=0 → sum=0xFE, carry=0. Then a=0x07, b=0x05, cin=1 → sum=0x01, carry=1, overflow=0.
- start held high for 3 cycles, with a/b changed mid-RUN → single result from the first captured operands. Restart in the DONE cycle → second done exactly 8 cycles later.
- Assert reset 4 cycles into RUN → busy=0, done never pulses, sum=0x00 and carry=0 immediately (async, no clock edge needed).
- WIDTH=16, BPC=4: a=0xFFFF, b=0x0001 → done 4 cycles after start; sum=0x0000, carry=1. Repeat 0x1234+0x4321 → sum=0x5555, carry=0.
